// File: rtl/fpu_mul_seq_pkg.sv
// Shared constants, state encoding and special-operand helpers for fpu_mul_seq.
// Optional radix-4 stepping is selected with FPU_MUL_RADIX4_EN.
package fpu_mul_seq_pkg;

  localparam int          FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_INF_EXP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2
  } state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

`ifdef FPU_MUL_RADIX4_EN
  localparam logic [4:0] CNT_STEP = 5'd2;
  localparam logic [4:0] CNT_LAST = 5'd22;
`else
  localparam logic [4:0] CNT_STEP = 5'd1;
  localparam logic [4:0] CNT_LAST = 5'd23;
`endif

  function automatic logic is_nan(fp32_t x);
    return (x.exp == FP_INF_EXP) && (x.frac != 23'h0);
  endfunction

  function automatic logic is_inf(fp32_t x);
    return (x.exp == FP_INF_EXP) && (x.frac == 23'h0);
  endfunction

  // Denormals count as zero: they are flushed before the datapath.
  function automatic logic is_zero(fp32_t x);
    return x.exp == 8'h00;
  endfunction

  function automatic logic is_special(fp32_t x, fp32_t y);
    return (x.exp == FP_INF_EXP) || (y.exp == FP_INF_EXP) ||
           is_zero(x) || is_zero(y);
  endfunction

  function automatic logic [31:0] special_res(fp32_t x, fp32_t y);
    logic s;
    s = x.sign ^ y.sign;
    if (is_nan(x) || is_nan(y) ||
        (is_inf(x) && is_zero(y)) ||
        (is_inf(y) && is_zero(x)))
      return FP_QNAN;
    if (is_inf(x) || is_inf(y))
      return {s, FP_INF_EXP, 23'h0};
    return {s, 31'h0};
  endfunction

endpackage

// File: rtl/fpu_mul_seq_if.sv
// Start/done handshake bundle between an FPU client and fpu_mul_seq.
// Master drives operands and start; slave returns busy, done and result.
interface fpu_mul_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/fpu_mul_seq_rne.sv
// Round-to-nearest-even of the bits below the implicit one.
// carry signals a mantissa overflow that bumps the exponent.
module round_to_nearest_even #(
  parameter int BITS_IN  = 46,
  parameter int BITS_OUT = 23
) (
  input  logic [BITS_IN-1:0]  din,
  output logic [BITS_OUT-1:0] dout,
  output logic                carry
);

  localparam int LO = BITS_IN - BITS_OUT;

  logic [BITS_OUT-1:0] keep;
  logic                guard;
  logic                sticky;
  logic                up;

  assign keep   = din[BITS_IN-1:LO];
  assign guard  = din[LO-1];
  assign sticky = |din[LO-2:0];
  assign up     = guard & (sticky | keep[0]);

  assign {carry, dout} = {1'b0, keep} + {{BITS_OUT{1'b0}}, up};

endmodule

// File: rtl/fpu_mul_seq.sv
// Iterative IEEE-754 single multiplier, shift-add, RNE, flush-to-zero.
// FPU_MUL_RADIX4_EN retires two multiplier bits per MUL edge.
module fpu_mul_seq
  import fpu_mul_seq_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  fpu_mul_seq_if.slave bus
);

  fp32_t fa;
  fp32_t fb;
  assign fa = bus.a;
  assign fb = bus.b;

  state_t      state;
  logic [4:0]  cnt;
  logic [47:0] acc;
  logic [23:0] ma;
  logic [23:0] mb;
  logic [9:0]  exp_q;
  logic        sgn_q;
  logic        spec_q;
  logic [31:0] spec_val_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] res_q;

  logic [9:0]  exp_sum;
  assign exp_sum = {2'b0, fa.exp} + {2'b0, fb.exp} - 10'(FP_BIAS);

  logic [47:0] ma_ext;
  logic [47:0] pp;
  assign ma_ext = {24'h0, ma};

`ifdef FPU_MUL_RADIX4_EN
  logic [4:0]  cnt_hi;
  assign cnt_hi = cnt + 5'd1;
  assign pp = (mb[cnt]    ? (ma_ext << cnt)    : 48'h0) +
              (mb[cnt_hi] ? (ma_ext << cnt_hi) : 48'h0);
`else
  assign pp = mb[cnt] ? (ma_ext << cnt) : 48'h0;
`endif

  // Fold p[1:0] into one sticky bit so both alignments fit the rounder.
  logic [45:0] rnd_in;
  logic [22:0] frac_r;
  logic        rnd_c;
  assign rnd_in = acc[47] ? {acc[46:2], acc[1] | acc[0]}
                          : acc[45:0];

  round_to_nearest_even #(
    .BITS_IN (46),
    .BITS_OUT(23)
  ) u_rne (
    .din  (rnd_in),
    .dout (frac_r),
    .carry(rnd_c)
  );

  logic [9:0]  exp_n;
  logic        ovf;
  logic        unf;
  logic [31:0] packed_res;
  assign exp_n = exp_q + {9'h0, acc[47]} + {9'h0, rnd_c};
  assign ovf   = $signed(exp_n) >= 10'sd255;
  assign unf   = $signed(exp_n) <= 10'sd0;

  always_comb begin
    packed_res = 32'h0;
    unique case (1'b1)
      ovf:     packed_res = {sgn_q, FP_INF_EXP, 23'h0};
      unf:     packed_res = {sgn_q, 31'h0};
      default: packed_res = {sgn_q, exp_n[7:0], frac_r};
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      acc        <= 48'h0;
      ma         <= 24'h0;
      mb         <= 24'h0;
      exp_q      <= 10'h0;
      sgn_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= 32'h0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // A start coinciding with done is dropped.
          if (bus.start && !done_q) begin
            sgn_q      <= fa.sign ^ fb.sign;
            exp_q      <= exp_sum;
            ma         <= {fa.exp != 8'h0, fa.frac};
            mb         <= {fb.exp != 8'h0, fb.frac};
            acc        <= 48'h0;
            cnt        <= 5'd0;
            spec_q     <= is_special(fa, fb);
            spec_val_q <= special_res(fa, fb);
            busy_q     <= 1'b1;
            state      <= is_special(fa, fb) ? NORM : MUL;
          end
        end
        MUL: begin
          acc <= acc + pp;
          cnt <= cnt + CNT_STEP;
          if (cnt == CNT_LAST)
            state <= NORM;
        end
        NORM: begin
          res_q  <= spec_q ? spec_val_q : packed_res;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule
